// File: rtl/quad_pkg.sv
// Shared types for the quadrature decoder: FSM states, the 2-bit {A,B} phase
// and the four phase encodings in forward order.
package quad_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_10 = 2'b10;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_01 = 2'b01;

  // Successor of a phase when the shaft turns forward.
  function automatic phase_t fwd_next(input phase_t p);
    case (p)
      PH_00:   fwd_next = PH_10;
      PH_10:   fwd_next = PH_11;
      PH_11:   fwd_next = PH_01;
      default: fwd_next = PH_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output level follows
// the synchronized input only after FILTER_LEN consecutive differing cycles.
module quad_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic stable
);

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN - 1);

  logic       s1;
  logic       s2;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      s1 <= din;
      s2 <= s1;
      // Any return to the accepted level discards a partial count.
      if (s2 == level) begin
        cnt <= 4'd0;
      end else if (cnt == CNT_MAX) begin
        level <= s2;
        cnt   <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  // Nothing in flight through the synchronizer or the filter.
  assign stable = (s1 == level) && (s2 == level);

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phases drive registered step/up/err pulses.
// Optional saturating error counter enabled by QUAD_ERR_CNT_EN.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  output logic       step,
  output logic       up,
  output logic       err,
`ifdef QUAD_ERR_CNT_EN
  input  logic       err_clr,
  output logic [7:0] err_cnt,
`endif
  output state_t     fsm_state
);

  localparam logic [3:0] INIT_MAX = 4'(FILTER_LEN - 1);

  phase_t     filt;
  logic       stab_a;
  logic       stab_b;
  state_t     state;
  state_t     state_n;
  phase_t     ph;
  phase_t     ph_n;
  logic [3:0] init_cnt;
  logic [3:0] init_cnt_n;
  logic       step_n;
  logic       up_n;
  logic       err_n;

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .din(a_in), .level(filt[1]), .stable(stab_a)
  );

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .din(b_in), .level(filt[0]), .stable(stab_b)
  );

  always_comb begin
    state_n    = state;
    ph_n       = ph;
    init_cnt_n = init_cnt;
    step_n     = 1'b0;
    err_n      = 1'b0;
    up_n       = up;
    case (state)
      INIT: begin
        // Adopt the phase silently once both channels have settled.
        if (stab_a && stab_b) begin
          if (init_cnt == INIT_MAX) begin
            state_n    = TRACK;
            ph_n       = filt;
            init_cnt_n = 4'd0;
          end else begin
            init_cnt_n = init_cnt + 4'd1;
          end
        end else begin
          init_cnt_n = 4'd0;
        end
      end
      TRACK: begin
        if (filt != ph) begin
          ph_n = filt;
          if (filt == ~ph) begin
            err_n = 1'b1;
          end else begin
            step_n = 1'b1;
            up_n   = (filt == fwd_next(ph));
          end
        end
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      ph       <= PH_00;
      init_cnt <= 4'd0;
      step     <= 1'b0;
      up       <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      ph       <= ph_n;
      init_cnt <= init_cnt_n;
      step     <= step_n;
      up       <= up_n;
      err      <= err_n;
    end
  end

  assign fsm_state = state;

`ifdef QUAD_ERR_CNT_EN
  // A clear in the same cycle as an err pulse still records that pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'd0;
    end else if (err_clr) begin
      err_cnt <= {7'd0, err};
    end else if (err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder (FILTER_LEN=4): directed phase sequences plus a
// random walk, with a timestamped expected-event queue and a monitor.
module tb_quad_decoder;
  import quad_pkg::*;

  localparam int FLEN = 4;
  localparam int LAT  = FLEN + 3;

  logic   clk = 1'b0;
  logic   rst;
  logic   a_in;
  logic   b_in;
  logic   step;
  logic   up;
  logic   err;
  state_t fsm_state;
`ifdef QUAD_ERR_CNT_EN
  logic       err_clr;
  logic [7:0] err_cnt;
`endif

  quad_decoder #(.FILTER_LEN(FLEN)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
    .step(step), .up(up), .err(err),
`ifdef QUAD_ERR_CNT_EN
    .err_clr(err_clr), .err_cnt(err_cnt),
`endif
    .fsm_state(fsm_state)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // expected events: {due cycle, is_err, up}
  logic [33:0] exp_q[$];

  // reference model: position of each phase in the forward cycle
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] model_ph = 2'b00;
  logic       model_up = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pos_of(input logic [1:0] p);
    int r = 0;
    for (int i = 0; i < 4; i++) if (seq[i] == p) r = i;
    return r;
  endfunction

  task automatic model_event(input logic [1:0] n);
    int d;
    if (n != model_ph) begin
      d = (pos_of(n) - pos_of(model_ph) + 4) % 4;
      if (d == 2) begin
        exp_q.push_back({32'(cyc + LAT), 1'b1, model_up});
      end else begin
        model_up = (d == 1);
        exp_q.push_back({32'(cyc + LAT), 1'b0, model_up});
      end
      model_ph = n;
    end
  endtask

  // driver tasks (entered on a falling edge)
  task automatic drive_phase(input logic [1:0] n, input int hold);
    a_in = n[1];
    b_in = n[0];
    model_event(n);
    repeat (hold) @(negedge clk);
  endtask

  task automatic glitch(input bit on_a, input int len);
    if (on_a) a_in = ~a_in; else b_in = ~b_in;
    repeat (len) @(negedge clk);
    if (on_a) a_in = ~a_in; else b_in = ~b_in;
    repeat (10) @(negedge clk);
  endtask

  // monitor / scoreboard
  logic [33:0] e;
  always @(negedge clk) begin
    if (!rst && (step || err)) begin
      check("step_err_exclusive", 32'(step & err), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event step=%0b err=%0b up=%0b required=none (cycle %0d)",
                 step, err, up, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", 32'(cyc), e[33:2]);
        check("event_is_err", 32'(err), 32'(e[1]));
        check("event_up", 32'(up), 32'(e[0]));
      end
    end
  end

  initial begin
    int k;
    rst  = 1'b1;
    a_in = 1'b0;
    b_in = 1'b0;
`ifdef QUAD_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_step", 32'(step), 32'd0);
    check("reset_up", 32'(up), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_state", 32'(fsm_state), 32'(INIT));
`ifdef QUAD_ERR_CNT_EN
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("init_to_track", 32'(fsm_state), 32'(TRACK));
    check("idle_up", 32'(up), 32'd0);

    // forward then reverse full cycles, then a short glitch on A
    foreach (seq[i]) drive_phase(seq[(i + 1) % 4], 10);
    for (int i = 3; i >= 0; i--) drive_phase(seq[i], 10);
    glitch(1'b1, 3);

    // illegal double change, then a legal forward step
    drive_phase(2'b11, 10);
`ifdef QUAD_ERR_CNT_EN
    check("err_cnt_one", 32'(err_cnt), 32'd1);
`endif
    drive_phase(2'b01, 10);
    check("up_after_fwd", 32'(up), 32'd1);

`ifdef QUAD_ERR_CNT_EN
    for (int i = 0; i < 260; i++) drive_phase(model_ph ^ 2'b11, 8);
    check("err_cnt_saturated", 32'(err_cnt), 32'd255);
    drive_phase(model_ph ^ 2'b11, 0);
    k = 0;
    while (k < 20 && !err) begin
      @(negedge clk);
      k++;
    end
    check("err_wait_timeout", 32'(err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr_with_err", 32'(err_cnt), 32'd1);
    repeat (8) @(negedge clk);
`endif

    // reset while the A filter count is part-way through
    drive_phase(2'b00, 10);
    a_in = 1'b1;
    b_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_state", 32'(fsm_state), 32'(INIT));
    rst = 1'b0;
    model_ph = 2'b10;
    model_up = 1'b0;
    repeat (20) @(negedge clk);
    check("midreset_track", 32'(fsm_state), 32'(TRACK));
    check("midreset_up", 32'(up), 32'd0);
    drive_phase(2'b11, 10);

    // random walk with occasional sub-threshold glitches
    for (int i = 0; i < 60; i++) begin
      drive_phase(2'($urandom_range(0, 3)), $urandom_range(9, 14));
      if ($urandom_range(0, 3) == 0) glitch(1'($urandom_range(0, 1)), $urandom_range(1, FLEN - 1));
    end

    repeat (20) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
